// File: rtl/bit_serializer.sv
// Word-to-bitstream serializer: valid/ready word FIFO feeding a shifter that
// emits one registered bit per clock, back-to-back across queued words.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MSB_FIRST = 1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din_word,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     dout_bit,
  output logic                     dout_valid,
  output logic                     dout_sof,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned NW = PW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   shreg;
  logic [CW-1:0]      bit_cnt;
  logic [WIDTH-1:0]   head;
  logic               push;
  logic               pop;
  logic               last_bit;

  assign din_ready = !rst && (fifo_count < NW'(DEPTH));
  assign push      = din_valid && din_ready;
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign head      = mem[rd_ptr];
  // A pop always coincides with loading the shifter: from IDLE, or right after the last bit.
  assign pop       = (fifo_count != '0) && ((state == IDLE) || (state == SHIFT && last_bit));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      dout_bit   <= IDLE_BIT;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (pop) begin
        state      <= SHIFT;
        busy       <= 1'b1;
        dout_valid <= 1'b1;
        dout_sof   <= 1'b1;
        bit_cnt    <= '0;
        if (MSB_FIRST != 0) begin
          dout_bit <= head[WIDTH-1];
          shreg    <= head << 1;
        end else begin
          dout_bit <= head[0];
          shreg    <= head >> 1;
        end
      end else if (state == SHIFT && !last_bit) begin
        dout_sof <= 1'b0;
        bit_cnt  <= bit_cnt + CW'(1);
        if (MSB_FIRST != 0) begin
          dout_bit <= shreg[WIDTH-1];
          shreg    <= shreg << 1;
        end else begin
          dout_bit <= shreg[0];
          shreg    <= shreg >> 1;
        end
      end else if (state == SHIFT) begin
        state      <= IDLE;
        busy       <= 1'b0;
        dout_valid <= 1'b0;
        dout_sof   <= 1'b0;
        dout_bit   <= IDLE_BIT;
        bit_cnt    <= '0;
      end
    end
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Word-to-bitstream serializer that feeds `mealy_fsm`: it accepts parallel words over a valid/ready handshake, buffers them in a small word FIFO, and shifts them out one bit per clock on `dout_bit`, which drives the FSM's `din_bit` directly. Words already queued are emitted back-to-back with no idle cycles between them, so the downstream sequence detector sees a contiguous stream across word boundaries. When it has no data, it drives a fixed idle bit and deasserts `dout_valid`.

## Interface
- `WIDTH`, default 8: bits per input word, at least 2.
- `DEPTH`, default 2: word FIFO depth; must be a power of two and at least 2.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: value of `dout_bit` whenever `dout_valid` is 0.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din_word`, input, `WIDTH`: parallel word to serialize.
- `din_valid`, input, 1: `din_word` is valid.
- `din_ready`, output, 1: the FIFO can accept a word this cycle.
- `dout_bit`, output, 1: serial bit, registered; connects to `mealy_fsm` `din_bit`.
- `dout_valid`, output, 1: `dout_bit` carries word data this cycle.
- `dout_sof`, output, 1: high only during the first bit of each word.
- `busy`, output, 1: the shifter holds a word (state SHIFT).
- `fifo_count`, output, `$clog2(DEPTH)+1`: number of words queued, excluding the word in the shifter.

## Operation
- **Handshake**
  - A word is accepted on a rising edge where `din_valid && din_ready`.
  - `din_ready = !rst && (fifo_count < DEPTH)`. It depends only on the reset and the registered count, never on `din_valid`.
  - The sender must hold `din_word` stable while `din_valid` is high and `din_ready` is low.
- **FIFO**
  - Circular buffer with read and write pointers that wrap modulo `DEPTH`.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - A push is never accepted while the FIFO is full, even if a pop occurs on the same edge.
- **Shifter FSM**
  - IDLE: `dout_valid=0`, `dout_bit=IDLE_BIT`. If `fifo_count>0`, pop the head word and go to SHIFT. The first bit is driven from that same edge, with `dout_sof=1`.
  - SHIFT: each edge drives the next bit and increments the bit counter (0..`WIDTH-1`).
  - On the edge after the last bit is driven:
    - if `fifo_count>0`, pop the next word, drive its first bit with `dout_sof=1`, and stay in SHIFT (no gap);
    - otherwise go to IDLE.
- **Bit order**
  - `MSB_FIRST=1`: bits go out as `word[WIDTH-1]` down to `word[0]`.
  - `MSB_FIRST=0`: bits go out as `word[0]` up to `word[WIDTH-1]`.
- **Reset**
  - Reset is asynchronous and may arrive at any time, including mid-word.
  - Immediately on assertion: state=IDLE, FIFO pointers and `fifo_count`=0, bit counter=0, `dout_bit=IDLE_BIT`, `dout_valid=0`, `dout_sof=0`, `busy=0`, `din_ready=0`.
  - The partial word in the shifter and all queued words are discarded and are never emitted.

## Timing
- **Latency:** a word accepted at edge N into an empty FIFO with the shifter in IDLE is loaded at edge N+1. Its bits appear in cycles N+1 through N+`WIDTH`, with `dout_sof` high in cycle N+1 only.
- **Throughput:** 1 bit/clk sustained, i.e. one word every `WIDTH` cycles, provided the FIFO stays non-empty.
- **Output timing:** all outputs except `din_ready` are registered. They change only on a rising edge or on reset assertion.
- **Reset release:** `din_ready` goes high combinationally when `rst` falls; the first word can be accepted at the next rising edge.

## Test plan
- **Reset:** hold `rst=1` for 15 ns, then release. Required during reset: `dout_bit=0`, `dout_valid=0`, `dout_sof=0`, `busy=0`, `fifo_count=0`, `din_ready=0`. Required after release: `din_ready=1`.
- **Single word** (`WIDTH=8`, `MSB_FIRST=1`): push 8'h67 at edge N. Required: `dout_bit` = 0,1,1,0,0,1,1,1 in cycles N+1..N+8; `dout_sof` high in cycle N+1 only; `dout_valid` and `busy` low from cycle N+9.
- **Back-to-back:** push 8'h67 and 8'hB4 on consecutive edges N and N+1. Required: 16 contiguous valid bits 0110_0111_1011_0100; `dout_sof` high in cycles N+1 and N+9; `fifo_count` returns to 0.
- **Backpressure** (`DEPTH=2`): hold `din_valid` high with words 8'h01, 8'h02, 8'h03, 8'h04 presented in order. Required: `din_ready` drops when `fifo_count=2`; exactly 32 bits emitted in push order; no word lost or duplicated.
- **LSB-first** (`MSB_FIRST=0`): push 8'h67. Required output: 1,1,1,0,0,1,1,0.
- **Mid-word reset:** assert `rst` after 3 bits of 8'h67 while 8'hB4 is queued. Required: outputs reach their reset values immediately; neither word resumes. After release, pushing 8'hB4 yields `dout_sof=1` and the bits 1,0,1,1,0,1,0,0.
